seq_adder32: RTL
================

// Module: seq_adder32
// PURPOSE
//  Multi-cycle 32-bit adder: the addition counterpart of the team's 32-bit borrow-look-ahead subtractor.
//  Adds A + B + CIN one CHUNK-bit slice per clock, LSB slice first, with carry registered between slices.
//  Start/busy/done handshake. Serves ALU/datapath paths where area matters more than single-cycle latency.
// PARAMETERS
//  WIDTH  32  operand/result width; must be an integer multiple of CHUNK
//  CHUNK  8   bits added per cycle; NCHUNK = WIDTH/CHUNK slices (default 4)
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only in IDLE or DONE
//  a         in   WIDTH  addend A, captured when start is accepted
//  b         in   WIDTH  addend B, captured when start is accepted
//  cin       in   1      carry-in, captured when start is accepted
//  busy      out  1      1 while in RUN
//  done      out  1      single-cycle pulse: result valid
//  sum       out  WIDTH  A+B+CIN mod 2^WIDTH
//  cout      out  1      unsigned carry out of bit WIDTH-1
//  overflow  out  1      signed overflow: a[W-1]==b[W-1] && sum[W-1]!=a[W-1]
// BEHAVIOUR
//  Reset (rst_n=0, any time, async): state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0,
//   slice index=0, working carry=0. Reset mid-RUN aborts the operation; no done is produced.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: start=1 at edge E0 latches a, b, cin into operand regs; carry<=cin, idx<=0, busy<=1, -> RUN.
//  RUN: each edge adds slice idx: {c,s} = a_r[idx] + b_r[idx] + carry; s goes to working reg slice idx;
//   carry<=c; idx<=idx+1. The edge that processes idx=NCHUNK-1 loads sum/cout/overflow from the
//   working reg and final carry, sets busy<=0, done<=1, -> DONE.
//  Latency: start accepted at E0 -> done=1 in the cycle following edge E0+NCHUNK (4 cycles at default).
//  DONE: lasts exactly one cycle. start=1 here is accepted as in IDLE (back-to-back ops,
//   throughput 1 result per NCHUNK+1 cycles); otherwise -> IDLE.
//  start while in RUN: ignored; latched operands are not disturbed; no queuing.
//  a/b/cin may change freely after acceptance without affecting the result.
//  sum/cout/overflow change only at the completing edge or reset; held stable from done until the
//   next completion (partial sums are never visible on outputs).
//  Arithmetic: unsigned modulo 2^WIDTH; cout = carry out of final slice; overflow computed from the
//   latched operand sign bits and the final sum MSB.
//  Subtraction use: a + ~b with cin=1 yields a-b; cout=1 means no borrow (equals ~bout of the subtractor).
// TESTING
//  1. 0x00000000+0x00000000, cin=0 -> done after 4 cycles; sum=0, cout=0, ovf=0; busy high exactly 4 cycles.
//  2. 0xFFFFFFFF+0x00000001 -> sum=0, cout=1, ovf=0; 0x000000FF+0x00000001 -> sum=0x00000100 (slice carry).
//  3. 0x7FFFFFFF+0x00000001 -> sum=0x80000000, cout=0, ovf=1; 0x80000000+0x80000000 -> sum=0, cout=1, ovf=1.
//  4. Subtract via a+~b+1: a=0x23489ABC, b=0x12AFE847 -> sum=0x1098B275, cout=1;
//     a=0, b=1 -> sum=0xFFFFFFFF, cout=0 (borrow).
//  5. start pulsed mid-RUN with different operands -> ignored, original result returned;
//     start held during DONE -> second op accepted, its done 5 cycles after the first.
//  6. rst_n low during RUN slice 2 -> all outputs 0 immediately, no done; next start completes normally.
//  Every case checked against a reference model {cout,sum} = a+b+cin; random sweep of >=1000 vectors.

Source files
------------

// File: rtl/seq_adder32.sv
// Multi-cycle adder: sums a + b + cin one CHUNK-bit slice per clock, LSB slice first,
// with a start/busy/done handshake. Results appear only on the completing edge.
module seq_adder32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] slice_a, slice_b;
  logic [CHUNK:0]   slice_res;
  logic [WIDTH-1:0] work_upd;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    slice_a   = a_q[idx_q*CHUNK +: CHUNK];
    slice_b   = b_q[idx_q*CHUNK +: CHUNK];
    slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};
    // Working value including the slice being added this cycle; used on the final edge.
    work_upd  = work_q;
    work_upd[idx_q*CHUNK +: CHUNK] = slice_res[CHUNK-1:0];

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          work_d  = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        work_d  = work_upd;
        carry_d = slice_res[CHUNK];
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          sum_d   = work_upd;
          cout_d  = slice_res[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_upd[WIDTH-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
